shifter_pipe: RTL and testbench
===============================

SHIFTER_PIPE -- requirements
Module: shifter_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 Parameter SPLIT, default 3, number of low shamt bits resolved in stage 1; legal range 1..SHW-1, where SHW = clog2(XLEN).
REQ-003 Parameter TAG_W, default 5, width of the sideband tag carried alongside each operation.
REQ-004 Port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-005 Port rst_n, input, 1, reset; asynchronous assert, active-low.
REQ-006 Port flush, input, 1, synchronous discard of all in-flight operations.
REQ-007 Port in_valid, input, 1, request present.
REQ-008 Port in_ready, output, 1, block accepts the request this cycle.
REQ-009 Port in_op, input, 3, operation: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 reserved.
REQ-010 Port in_word, input, 1, 32-bit word mode (RV64 *W ops); ignored when XLEN=32.
REQ-011 Port in_a, input, XLEN, operand.
REQ-012 Port in_shamt, input, SHW, shift amount.
REQ-013 Port in_tag, input, TAG_W, opaque tag.
REQ-014 Port out_valid, output, 1, result present.
REQ-015 Port out_ready, input, 1, consumer accepts the result.
REQ-016 Port out_result, output, XLEN, shifted value.
REQ-017 Port out_tag, output, TAG_W, tag of the result.

Function
REQ-018 A request is accepted when in_valid && in_ready; a result is taken when out_valid && out_ready.
REQ-019 Two register stages: S1 holds the operand after shamt[SPLIT-1:0] is applied; S2 holds the final result after shamt[SHW-1:SPLIT] is applied.
REQ-020 An accepted request appears on out_valid exactly 2 cycles later when no stall occurs; latency = 2, throughput = 1 per cycle.
REQ-021 S2 loads when S1 is valid and (S2 is empty or out_ready=1).
REQ-022 in_ready = !S1_valid || S1 advancing this cycle; simultaneous accept, advance and output in one cycle is legal.
REQ-023 Stalled stages hold data, tag, op and word bits unchanged; results never drop, duplicate or reorder.
REQ-024 SLL and SRL zero-fill; SRA fills with the operand MSB; ROL/ROR rotate with no loss of bits.
REQ-025 shamt=0 returns the operand unchanged for every non-reserved op.
REQ-026 Reserved ops complete normally with out_result = 0 and the tag preserved.
REQ-027 Word mode (XLEN=64, in_word=1): operand = in_a[31:0]; shamt uses in_shamt[4:0] only; rotates operate within 32 bits; SRA fills from bit 31; out_result is the 32-bit result sign-extended from its bit 31.
REQ-028 The shifter is implemented structurally as a log-stage mux cascade, one 2:1 layer per shamt bit.
REQ-029 flush=1 clears S1_valid and S2_valid at the next edge; a request presented in the same cycle is discarded; in_ready is 1 in the following cycle.
REQ-030 out_result and out_tag are don't-care while out_valid=0, but are held stable while out_valid=1 && out_ready=0.

Reset
REQ-031 While rst_n=0: S1_valid=0, S2_valid=0, out_valid=0, out_result=0, out_tag=0, and in_ready=1 after release.
REQ-032 Reset asserted mid-operation drops all in-flight results; no stale result emerges after release.
REQ-033 Data registers may omit reset, except those driving out_result and out_tag.

Verification
REQ-034 XLEN=32: SRA a=0x8000_0000, shamt=31 -> out_result=0xFFFF_FFFF two cycles later; SRL with the same inputs -> 0x0000_0001.
REQ-035 XLEN=32: ROR a=0x0000_0001, shamt=1 -> 0x8000_0000; ROL a=0x8000_0001, shamt=4 -> 0x0000_0018; SLL shamt=0 -> a unchanged.
REQ-036 XLEN=64 word mode, a=0xFFFF_FFFF_8000_0000, shamt=4: SRLW -> 0x0000_0000_0800_0000; SRAW -> 0xFFFF_FFFF_F800_0000.
REQ-037 Backpressure: with out_ready=0, send 3 back-to-back requests with tags 1,2,3 -> in_ready drops after 2 are accepted; on release, results exit in order 1,2,3 with no loss.
REQ-038 flush with both stages full plus a new request in the same cycle -> out_valid=0 next cycle and no result appears for any of the 3 requests.
REQ-039 Random ops, shamt values and ready patterns against a reference model, plus rst_n pulsed mid-stream -> zero mismatches and no result after reset for pre-reset requests.

Source files
------------

// File: rtl/shifter_pipe.sv
// shifter_pipe: two-stage shift/rotate unit; low shamt bits in S1, high in S2.
// Ports: clk, rst_n, flush; in_* request handshake; out_* result handshake.
module shifter_pipe #(
   parameter int XLEN  = 32,
   parameter int SPLIT = 3,
   parameter int TAG_W = 5,
   localparam int SHW  = $clog2(XLEN)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic             in_word,
   input  logic [XLEN-1:0]  in_a,
   input  logic [SHW-1:0]   in_shamt,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic [TAG_W-1:0] out_tag
);

   localparam int HIW = SHW - SPLIT;

   localparam logic [2:0] OP_SLL = 3'd0;
   localparam logic [2:0] OP_SRL = 3'd1;
   localparam logic [2:0] OP_SRA = 3'd2;
   localparam logic [2:0] OP_ROL = 3'd3;
   localparam logic [2:0] OP_ROR = 3'd4;

   // One 2:1 mux layer: shift/rotate by a fixed power of two.
   function automatic logic [XLEN-1:0] layer(
      input logic [XLEN-1:0] x,
      input logic [2:0]      op,
      input int              n
   );
      logic [XLEN-1:0] r;
      case (op)
         OP_SLL:  r = x << n;
         OP_SRL:  r = x >> n;
         OP_SRA:  r = $signed(x) >>> n;
         OP_ROL:  r = (x << n) | (x >> (XLEN - n));
         OP_ROR:  r = (x >> n) | (x << (XLEN - n));
         default: r = x;
      endcase
      return r;
   endfunction

   logic             s1_v;
   logic [XLEN-1:0]  s1_data;
   logic [2:0]       s1_op;
   logic             s1_word;
   logic [HIW-1:0]   s1_hi;
   logic [TAG_W-1:0] s1_tag;

   logic             s2_v;
   logic [XLEN-1:0]  s2_res;
   logic [TAG_W-1:0] s2_tag;

   logic             word_en;
   logic             s2_load;
   logic             accept;
   logic [XLEN-1:0]  prep;
   logic [SHW-1:0]   sh;
   logic [XLEN-1:0]  x1;
   logic [XLEN-1:0]  x2;

   assign word_en  = (XLEN == 64) && in_word;
   assign s2_load  = s1_v && (!s2_v || out_ready);
   assign in_ready = !s1_v || s2_load;
   assign accept   = in_valid && in_ready;

   // Word mode widens the 32-bit operand so a full-width cascade gives
   // the right low half: duplicate for rotates, sign for SRA, else zero.
   always_comb begin
      prep = in_a;
      sh   = in_shamt;
      if (word_en) begin
         sh[SHW-1] = 1'b0;
         for (int i = 32; i < XLEN; i++) begin
            if (in_op == OP_ROL || in_op == OP_ROR)
               prep[i] = in_a[i-32];
            else if (in_op == OP_SRA)
               prep[i] = in_a[31];
            else
               prep[i] = 1'b0;
         end
      end
      // Reserved ops: a zero operand stays zero through every layer.
      if (in_op > OP_ROR)
         prep = '0;
   end

   always_comb begin
      x1 = prep;
      for (int k = 0; k < SPLIT; k++)
         if (sh[k])
            x1 = layer(x1, in_op, 1 << k);
   end

   always_comb begin
      x2 = s1_data;
      for (int k = 0; k < HIW; k++)
         if (s1_hi[k])
            x2 = layer(x2, s1_op, 1 << (k + SPLIT));
      for (int i = 32; i < XLEN; i++)
         if (s1_word)
            x2[i] = x2[31];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v    <= 1'b0;
         s1_data <= '0;
         s1_op   <= '0;
         s1_word <= 1'b0;
         s1_hi   <= '0;
         s1_tag  <= '0;
      end else begin
         if (flush)
            s1_v <= 1'b0;
         else
            s1_v <= accept || (s1_v && !s2_load);
         if (accept) begin
            s1_data <= x1;
            s1_op   <= in_op;
            s1_word <= word_en;
            s1_hi   <= sh[SHW-1:SPLIT];
            s1_tag  <= in_tag;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_v   <= 1'b0;
         s2_res <= '0;
         s2_tag <= '0;
      end else begin
         if (flush)
            s2_v <= 1'b0;
         else
            s2_v <= s2_load || (s2_v && !out_ready);
         if (s2_load) begin
            s2_res <= x2;
            s2_tag <= s1_tag;
         end
      end
   end

   assign out_valid  = s2_v;
   assign out_result = s2_res;
   assign out_tag    = s2_tag;

endmodule

// File: tb/tb_shifter_pipe.sv
// tb_shifter_pipe: scoreboard bench for XLEN=32 and XLEN=64 instances.
// Both instances share stimulus; each has its own expectation queue.
module tb_shifter_pipe;

   typedef struct {
      logic [63:0] r;
      logic [4:0]  t;
   } exp_t;

   logic        clk = 0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic [2:0]  op;
   logic        word;
   logic [63:0] a;
   logic [5:0]  sh;
   logic [4:0]  tag;
   logic        out_ready;
   bit          rnd_rdy;

   logic        ir32, ov32;
   logic [31:0] res32;
   logic [4:0]  tg32;
   logic        ir64, ov64;
   logic [63:0] res64;
   logic [4:0]  tg64;

   int checks = 0;
   int errors = 0;
   exp_t q32[$];
   exp_t q64[$];

   always #5 clk = ~clk;

   shifter_pipe #(.XLEN(32), .SPLIT(3), .TAG_W(5)) dut32 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(ir32),
      .in_op(op), .in_word(word), .in_a(a[31:0]),
      .in_shamt(sh[4:0]), .in_tag(tag),
      .out_valid(ov32), .out_ready(out_ready),
      .out_result(res32), .out_tag(tg32)
   );

   shifter_pipe #(.XLEN(64), .SPLIT(3), .TAG_W(5)) dut64 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(ir64),
      .in_op(op), .in_word(word), .in_a(a),
      .in_shamt(sh), .in_tag(tag),
      .out_valid(ov64), .out_ready(out_ready),
      .out_result(res64), .out_tag(tg64)
   );

   // Reference: plain arithmetic on a w-bit value.
   function automatic logic [63:0] model(
      input int xl, input logic [2:0] o, input logic w,
      input logic [63:0] av, input logic [5:0] s6
   );
      logic [63:0] v, m, r;
      int wd, s;
      if (o > 3'd4) return 64'd0;
      if (xl == 32 || w) begin
         wd = 32; s = int'(s6[4:0]);
      end else begin
         wd = 64; s = int'(s6);
      end
      m = (wd == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      v = av & m;
      case (o)
         3'd0: r = (v << s) & m;
         3'd1: r = v >> s;
         3'd2: r = (v >> s) | (v[wd-1] ? (m & ~(m >> s)) : 64'd0);
         3'd3: r = (s == 0) ? v : (((v << s) | (v >> (wd - s))) & m);
         3'd4: r = (s == 0) ? v : (((v >> s) | (v << (wd - s))) & m);
         default: r = 64'd0;
      endcase
      if (xl == 64 && w) r = {{32{r[31]}}, r[31:0]};
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: samples 1 time unit after the falling edge.
   always @(negedge clk) begin
      exp_t e;
      #1;
      if (!rst_n) begin
         q32.delete();
         q64.delete();
         chk("rst_out32", {26'd0, ov32, tg32, res32}, 64'd0);
         chk("rst_res64", res64, 64'd0);
         chk("rst_vt64", {58'd0, ov64, tg64}, 64'd0);
      end else begin
         if (ov32 && out_ready) begin
            if (q32.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected32: got tag %0d expected none", tg32);
            end else begin
               e = q32.pop_front();
               chk("res32", {32'd0, res32}, e.r);
               chk("tag32", {59'd0, tg32}, {59'd0, e.t});
            end
         end
         if (ov64 && out_ready) begin
            if (q64.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected64: got tag %0d expected none", tg64);
            end else begin
               e = q64.pop_front();
               chk("res64", res64, e.r);
               chk("tag64", {59'd0, tg64}, {59'd0, e.t});
            end
         end
         if (in_valid && !flush && ir32)
            q32.push_back('{model(32, op, word, a, sh), tag});
         if (in_valid && !flush && ir64)
            q64.push_back('{model(64, op, word, a, sh), tag});
         if (flush) begin
            q32.delete();
            q64.delete();
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   // Present one request and hold it until accepted (bounded).
   task automatic drive_req(input logic [2:0] o, input logic w,
                            input logic [63:0] av, input logic [5:0] s,
                            input logic [4:0] t);
      int n;
      tick();
      op = o; word = w; a = av; sh = s; tag = t;
      in_valid = 1'b1;
      n = 0;
      #2;
      while (!ir32 && n < 200) begin
         tick();
         #2;
         n++;
      end
      if (!ir32) chk("accept_timeout", {63'd0, ir32}, 64'd1);
   endtask

   task automatic drive_rand();
      drive_req(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                {$urandom(), $urandom()}, 6'($urandom_range(0, 63)),
                5'($urandom));
   endtask

   // Single request into an empty pipe; checks 2-cycle latency and value.
   task automatic dir(input bit sel64, input logic [2:0] o, input logic w,
                      input logic [63:0] av, input logic [5:0] s,
                      input logic [63:0] e, input string nm);
      logic [63:0] rv;
      tick();
      op = o; word = w; a = av; sh = s; tag = 5'($urandom);
      in_valid = 1'b1;
      #2;
      chk({nm, "_rdy"}, {63'd0, sel64 ? ir64 : ir32}, 64'd1);
      tick();
      in_valid = 1'b0;
      #2;
      chk({nm, "_lat1"}, {63'd0, sel64 ? ov64 : ov32}, 64'd0);
      tick();
      #2;
      chk({nm, "_lat2"}, {63'd0, sel64 ? ov64 : ov32}, 64'd1);
      rv = sel64 ? res64 : {32'd0, res32};
      chk(nm, rv, e);
   endtask

   task automatic drain(input int cyc);
      out_ready = 1'b1;
      for (int i = 0; i < cyc; i++) tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 0; flush = 0; in_valid = 0; op = 0; word = 0;
      a = 0; sh = 0; tag = 0; out_ready = 1; rnd_rdy = 0;
      repeat (3) tick();
      rst_n = 1;
      #2;
      chk("rdy_after_rst32", {63'd0, ir32}, 64'd1);
      chk("rdy_after_rst64", {63'd0, ir64}, 64'd1);

      dir(0, 3'd2, 0, 64'h8000_0000, 6'd31, 64'hFFFF_FFFF, "sra31");
      dir(0, 3'd1, 0, 64'h8000_0000, 6'd31, 64'h0000_0001, "srl31");
      dir(0, 3'd4, 0, 64'h0000_0001, 6'd1, 64'h8000_0000, "ror1");
      dir(0, 3'd3, 0, 64'h8000_0001, 6'd4, 64'h0000_0018, "rol4");
      dir(0, 3'd0, 0, 64'h1234_5678, 6'd0, 64'h1234_5678, "sll0");
      dir(0, 3'd6, 0, 64'hDEAD_BEEF, 6'd7, 64'd0, "rsvd32");
      dir(1, 3'd1, 1, 64'hFFFF_FFFF_8000_0000, 6'd4,
          64'h0000_0000_0800_0000, "srlw");
      dir(1, 3'd2, 1, 64'hFFFF_FFFF_8000_0000, 6'd4,
          64'hFFFF_FFFF_F800_0000, "sraw");
      dir(1, 3'd4, 0, 64'h0000_0000_0000_0001, 6'd1,
          64'h8000_0000_0000_0000, "ror64");
      drain(3);

      // Backpressure: third request must stall with two held.
      out_ready = 1'b0;
      drive_req(3'd0, 0, 64'h11, 6'd1, 5'd1);
      drive_req(3'd1, 0, 64'h22, 6'd1, 5'd2);
      tick();
      op = 3'd3; word = 0; a = 64'h33; sh = 6'd2; tag = 5'd3;
      in_valid = 1'b1;
      #2;
      chk("bp_stall_rdy", {63'd0, ir32}, 64'd0);
      chk("bp_hold_tag", {59'd0, tg32}, 64'd1);
      tick();
      #2;
      chk("bp_stall_rdy2", {63'd0, ir32}, 64'd0);
      chk("bp_hold_tag2", {59'd0, tg32}, 64'd1);
      chk("bp_hold_res", {32'd0, res32}, 64'h22);
      tick();
      out_ready = 1'b1;
      #2;
      chk("bp_release_rdy", {63'd0, ir32}, 64'd1);
      tick();
      in_valid = 1'b0;
      drain(4);
      chk("bp_drained32", 64'(q32.size()), 64'd0);

      // Flush with both stages full plus a new request.
      out_ready = 1'b0;
      drive_rand();
      drive_rand();
      tick();
      op = 3'd0; a = 64'h5; sh = 6'd1; tag = 5'd9;
      in_valid = 1'b1;
      flush = 1'b1;
      #2;
      chk("fl_full", {62'd0, ov32, ov64}, 64'd3);
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      #2;
      chk("fl_ov", {62'd0, ov32, ov64}, 64'd0);
      chk("fl_rdy", {62'd0, ir32, ir64}, 64'd3);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         #2;
         chk("fl_quiet", {62'd0, ov32, ov64}, 64'd0);
      end

      // Random traffic with a mid-stream reset pulse.
      rnd_rdy = 1;
      for (int i = 0; i < 400; i++) begin
         if (i == 200) begin
            tick();
            rst_n = 1'b0;
            in_valid = 1'b0;
            tick();
            tick();
            rst_n = 1'b1;
            #2;
            chk("rdy_after_pulse", {62'd0, ir32, ir64}, 64'd3);
         end
         if ($urandom_range(0, 3) == 0) begin
            tick();
            in_valid = 1'b0;
         end else begin
            drive_rand();
         end
      end
      rnd_rdy = 0;
      tick();
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (q32.size() == 0 && q64.size() == 0 && !ov32 && !ov64) break;
         tick();
      end
      chk("drain32", 64'(q32.size()), 64'd0);
      chk("drain64", 64'(q64.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
